// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry pipeline register with a skid buffer. It cuts every combinational
// path between the producer and the consumer handshakes. in_ready, out_valid,
// out_data and count all come straight from flops, so neither side sees the
// other's timing. When the consumer stalls, one extra beat lands in the skid
// register. That beat is the one already in flight under the registered
// in_ready. Full throughput (one beat per cycle) holds while both sides stream.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of all held entries (highest priority)
//   in_valid   producer offers in_data
//   in_data    producer payload, WIDTH bits
//   in_ready   block accepts in_data this cycle (registered)
//   out_valid  out_data holds a valid entry (registered)
//   out_data   oldest held payload (registered, the "main" register)
//   out_ready  consumer takes out_data this cycle
//   count      number of held entries, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // Encodings equal the occupancy, so count is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;

  logic             accept;
  logic             emit;
  logic             load_main_in;    // main <= in_data
  logic             load_main_skid;  // main <= skid (drain the skid slot)
  logic             load_skid;       // skid <= in_data

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and register-load decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first. A path
  // that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (accept && !emit) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready_q is 0 here, so nothing can be accepted.
        if (emit) begin
          load_main_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Flush overrides everything. The data registers are left as they are
    // because out_valid drops, so their contents no longer matter.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // in_ready is held at 0 during reset. It rises on the first edge after
  // release, because next state is then EMPTY rather than FULL.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample pre-edge values, with no ordering races between always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  // NOTE: payload registers normally skip reset. These two are cleared anyway
  // so that out_data reads 0 while the block is held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the payload width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 SHALL have port in_data, input, WIDTH bits: the producer payload.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 SHALL have port out_data, output, WIDTH bits: the oldest held payload.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-011 SHALL have port count, output, 2 bits: the number of held entries (0..2).

Function
REQ-012 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready, both evaluated in the same cycle.
REQ-013 SHALL hold two WIDTH-bit registers: main (which drives out_data) and skid.
REQ-014 SHALL implement states EMPTY (count 0), BUSY (count 1) and FULL (count 2).
REQ-015 SHALL, in EMPTY, on accept load main from in_data and go to BUSY; otherwise stay in EMPTY.
REQ-016 SHALL, in BUSY: accept with no emit loads skid from in_data and goes to FULL; accept with emit loads main from in_data and stays in BUSY; emit with no accept goes to EMPTY; neither holds state.
REQ-017 SHALL, in FULL, on emit load main from skid and go to BUSY; otherwise hold.
REQ-018 SHALL drive in_ready from a register, set at each edge to (next state != FULL), so that in_ready never depends combinationally on out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY), count from state, and out_data = main, all register-sourced.
REQ-020 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL ignore in_data whenever accept=0; in_valid asserted in FULL SHALL NOT be accepted and SHALL NOT corrupt stored data.
REQ-022 SHALL deliver entries in acceptance order with no loss or duplication; latency from accept to out_valid SHALL be 1 cycle when empty.
REQ-023 SHALL support sustained throughput of 1 entry per cycle with in_valid=out_ready=1 continuously.
REQ-024 SHALL treat flush as highest priority: at the next edge go to EMPTY with in_ready=1 and count=0, and discard any entry accepted or emitted in that cycle.
REQ-025 SHALL leave the contents of main and skid unchanged on flush (do-not-care, since out_valid=0).

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force state EMPTY, out_valid=0, count=0, in_ready=0, main=0 and skid=0.
REQ-027 SHALL raise in_ready to 1 at the first rising clk edge after rst deasserts.
REQ-028 SHALL, when rst asserts mid-transfer (state BUSY or FULL), drop all held entries immediately with no emit.

Verification
REQ-029 Reset release followed by in_valid=1, in_data=0x11 with out_ready=0 -> in_ready=1 after the first edge; next cycle out_valid=1, out_data=0x11, count=1.
REQ-030 Backpressure: with out_ready=0, offer 0xA1 then 0xA2 -> count=2, in_ready=0; 0xA3 held on in_valid is not taken; then out_ready=1 -> outputs 0xA1, 0xA2, 0xA3 in order with no gaps once 0xA3 is accepted.
REQ-031 Streaming: in_valid=out_ready=1 for 8 cycles carrying 0..7 -> out_data 0..7 on consecutive cycles; in_ready stays 1; count stays 1.
REQ-032 Flush in FULL coinciding with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1; the flushed and offered entries never appear at the output.
REQ-033 rst asserted asynchronously between edges in BUSY -> out_valid and in_ready drop to 0 without waiting for a clock edge; after release, the first accepted value is the first output.
REQ-034 Random valid/ready toggling for 10k cycles against a scoreboard model -> order preserved, no loss or duplication, REQ-020 holds throughout, count always matches the model occupancy.
